// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
// State encodings are fixed so that external observers can decode them.
package serial_adder_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit combinational full adder; the only arithmetic in the serial adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first, one bit per clock.
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | shifting one sum bit per clock, busy=1
// DONE  | result held until the consumer takes it, out_valid=1
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEFAULT,
  localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             busy
);

  state_t state, state_next;

  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_next, s_ext;
  logic             carry;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] s_reg;
  logic             cout_reg;
  logic             s_bit, c_bit;
  logic             last_bit;

  fa_cell u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (s_bit),
    .cout (c_bit)
  );

  // Built this way so that WIDTH=1 never forms an empty slice.
  always_comb begin
    s_ext            = '0;
    s_ext[WIDTH-1]   = s_bit;
    sum_next         = (sum_sh >> 1) | s_ext;
  end

  assign last_bit = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_bit)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Operands are captured only on an accepted handshake, so X on idle inputs never enters state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      carry    <= 1'b0;
      count    <= '0;
      s_reg    <= '0;
      cout_reg <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_sh   <= A;
      b_sh   <= B;
      carry  <= Cin;
      sum_sh <= '0;
      count  <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      sum_sh <= sum_next;
      carry  <= c_bit;
      if (last_bit) begin
        s_reg    <= sum_next;
        cout_reg <= c_bit;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);
  assign S         = s_reg;
  assign Cout      = cout_reg;

endmodule
